// File: rtl/alu_retry_ctrl.sv
// Transaction controller around the checked 3-bit add/subtract datapath.
// Retries failing evaluations, tags unrecoverable results, counts errors, locks out on repeated faults.
module alu_retry_ctrl #(
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned FAULT_LIMIT = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_a,
  input  logic [2:0]       in_b,
  input  logic             in_par,
  input  logic [2:0]       in_c,
  output logic [2:0]       alu_a,
  output logic [2:0]       alu_b,
  output logic             alu_par,
  output logic [2:0]       alu_c,
  input  logic [2:0]       alu_x,
  input  logic             alu_xc,
  input  logic             alu_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_x,
  output logic             out_xc,
  output logic             out_fault,
  output logic [CNT_W-1:0] err_count,
  output logic             locked
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned FW = $clog2(FAULT_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_OUT  = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_c_q, alu_c_d;
  logic             alu_par_q, alu_par_d;
  logic [2:0]       out_x_q, out_x_d;
  logic             out_xc_q, out_xc_d, out_fault_q, out_fault_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [FW-1:0]    consec_q, consec_d;
  logic             retry_done;

  assign retry_done = (retry_q == RW'(MAX_RETRY));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_EVAL;
      S_EVAL: if (!alu_err || retry_done) state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = (consec_q == FW'(FAULT_LIMIT)) ? S_LOCK : S_IDLE;
      S_LOCK: state_d = S_LOCK;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status decode of the registered state
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
    locked    = (state_q == S_LOCK);
  end

  // Operand, result and counter updates
  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_c_d     = alu_c_q;
    alu_par_d   = alu_par_q;
    out_x_d     = out_x_q;
    out_xc_d    = out_xc_q;
    out_fault_d = out_fault_q;
    err_count_d = err_count_q;
    retry_d     = retry_q;
    consec_d    = consec_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          alu_a_d   = in_a;
          alu_b_d   = in_b;
          alu_c_d   = in_c;
          alu_par_d = in_par;
          retry_d   = '0;
        end
      end
      S_EVAL: begin
        if (!alu_err) begin
          out_x_d     = alu_x;
          out_xc_d    = alu_xc;
          out_fault_d = 1'b0;
          consec_d    = '0;
        end else begin
          if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
          if (!retry_done) begin
            retry_d = retry_q + RW'(1);
          end else begin
            out_x_d     = alu_x;
            out_xc_d    = alu_xc;
            out_fault_d = 1'b1;
            if (consec_q != FW'(FAULT_LIMIT)) consec_d = consec_q + FW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_q     <= '0;
      alu_par_q   <= 1'b0;
      out_x_q     <= '0;
      out_xc_q    <= 1'b0;
      out_fault_q <= 1'b0;
      err_count_q <= '0;
      retry_q     <= '0;
      consec_q    <= '0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_c_q     <= alu_c_d;
      alu_par_q   <= alu_par_d;
      out_x_q     <= out_x_d;
      out_xc_q    <= out_xc_d;
      out_fault_q <= out_fault_d;
      err_count_q <= err_count_d;
      retry_q     <= retry_d;
      consec_q    <= consec_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign alu_par   = alu_par_q;
  assign out_x     = out_x_q;
  assign out_xc    = out_xc_q;
  assign out_fault = out_fault_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_retry_ctrl.sv
// Directed bench for alu_retry_ctrl: clean, transient, persistent, lockout, backpressure, reset, saturation.
module tb_alu_retry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_par, out_ready, err_mode;
  logic [2:0] in_a, in_b, in_c;
  logic [2:0] alu_a, alu_b, alu_c, alu_x, out_x;
  logic       alu_par, alu_xc, alu_err, out_valid, out_xc, out_fault, locked, in_ready;
  logic [7:0] err_count;
  logic [2:0] alu_a2, alu_b2, alu_c2, out_x2;
  logic       alu_par2, out_valid2, out_xc2, out_fault2, locked2, in_ready2;
  logic [1:0] err_count2;
  logic [3:0] sum;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // Datapath model: plain add of the registered operands, error flag forced by the bench
  assign sum     = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_x   = sum[2:0];
  assign alu_xc  = sum[3];
  assign alu_err = err_mode;

  alu_retry_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_par(in_par), .in_c(in_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_par(alu_par), .alu_c(alu_c),
    .alu_x(alu_x), .alu_xc(alu_xc), .alu_err(alu_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_xc(out_xc),
    .out_fault(out_fault), .err_count(err_count), .locked(locked)
  );

  alu_retry_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_par(in_par), .in_c(in_c),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_par(alu_par2), .alu_c(alu_c2),
    .alu_x(alu_x), .alu_xc(alu_xc), .alu_err(alu_err),
    .out_valid(out_valid2), .out_ready(out_ready), .out_x(out_x2), .out_xc(out_xc2),
    .out_fault(out_fault2), .err_count(err_count2), .locked(locked2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_edge();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_x", 32'(out_x), 0);
    chk("rst_out_xc", 32'(out_xc), 0);
    chk("rst_out_fault", 32'(out_fault), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_alu_ab", 32'({alu_a, alu_b}), 0);
    chk("rst_alu_c_par", 32'({alu_c, alu_par}), 0);
    chk("rst_err_count2", 32'(err_count2), 0);
    rst_n = 1'b1;
  endtask

  // Offer one op; error flag held high for the first nerr evaluations; check latency and result
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input int nerr,
                        input int exp_lat, input logic exp_fault, input int exp_errs);
    int cyc;
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    in_valid = 1'b1; in_a = a; in_b = b; in_c = 3'b001; in_par = ^{a, b};
    err_mode = (nerr > 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      chk("alu_held", 32'({alu_a, alu_b, alu_c}), 32'({a, b, 3'b001}));
      @(posedge clk); #1;
      cyc++;
      err_mode = (cyc < nerr);
    end
    err_mode = 1'b0;
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("out_x", 32'(out_x), 32'(s[2:0]));
    chk("out_xc", 32'(out_xc), 32'(s[3]));
    chk("out_fault", 32'(out_fault), 32'(exp_fault));
    chk("err_count", 32'(err_count), 32'(exp_errs));
  endtask

  task automatic consume(input int hold);
    logic [4:0] snap;
    snap = {out_x, out_xc, out_fault};
    repeat (hold) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_stable", 32'({out_x, out_xc, out_fault}), 32'(snap));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_par = 1'b0;
    out_ready = 1'b0; err_mode = 1'b0;
    @(posedge clk); #1;
    reset_edge();

    run_op(3'd3, 3'd1, 0, 1, 1'b0, 0);
    consume(0);
    chk("idle_after_clean", 32'(in_ready), 1);
    run_op(3'd2, 3'd3, 1, 2, 1'b0, 1);
    consume(0);
    run_op(3'd7, 3'd6, 99, 3, 1'b1, 4);
    chk("sat_cnt2", 32'(err_count2), 3);
    consume(5);
    chk("idle_after_bp", 32'(in_ready), 1);
    run_op(3'd1, 3'd1, 0, 1, 1'b0, 4);
    consume(0);
    run_op(3'd5, 3'd5, 99, 3, 1'b1, 7);
    consume(0);
    run_op(3'd4, 3'd2, 99, 3, 1'b1, 10);
    consume(0);
    chk("no_lock_after_clean_gap", 32'(locked), 0);
    chk("ready_after_two", 32'(in_ready), 1);
    run_op(3'd6, 3'd6, 99, 3, 1'b1, 13);
    consume(0);
    chk("locked", 32'(locked), 1);
    in_valid = 1'b1; in_a = 3'd1; in_b = 3'd2;
    repeat (20) begin
      chk("lock_in_ready", 32'({in_ready, out_valid, locked}), 32'(3'b001));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset_edge();

    in_valid = 1'b1; in_a = 3'd2; in_b = 3'd2; err_mode = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_edge();
    err_mode = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'({out_valid, in_ready}), 32'(2'b01));
    end

    run_op(3'd1, 3'd2, 99, 3, 1'b1, 3);
    consume(0);
    run_op(3'd3, 3'd3, 1, 2, 1'b0, 4);
    consume(0);
    run_op(3'd0, 3'd7, 1, 2, 1'b0, 5);
    consume(0);
    chk("cnt2_saturated", 32'(err_count2), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
